io_sequencer: RTL and testbench

Front-end instruction sequencer for the 8-bit microprocessor. Takes a 16-bit instruction word from the board switches and a debounced execute button. Drives the 4-bit `Opcode` and the 3-bit phase code `pst` consumed by the control decoder, plus register addresses, immediate and a write-back strobe for the register file. It is the issuing end of the Opcode/`pst` interface: it produces exactly one decode phase (`pst = 3'b001`) per accepted instruction.

---
 rtl/io_sequencer.sv | 154 +++++++++++++++
 tb/tb_io_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_sequencer.sv
// io_sequencer
// Front-end instruction sequencer. Debounces the execute button, latches the
// switch instruction word on each accepted press and steps through the
// DECODE / EXECUTE / WRITEBACK / DONE phases, one cycle each.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_exec     raw execute button (asynchronous, bouncing)
//   sw_instr     instruction word: [15:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [7:0] imm
//   Opcode       latched opcode
//   pst          phase code: 000 IDLE, 001 DECODE, 010 EXECUTE, 011 WRITEBACK, 100 DONE
//   rd_addr, rs_addr, rt_addr   latched register addresses
//   imm          latched immediate
//   wb_strobe    high only during WRITEBACK
//   busy         high whenever pst != 000
//   instr_count  instructions that reached DONE, wraps at 256
module io_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_exec,
    input  logic [15:0] sw_instr,
    output logic [3:0]  Opcode,
    output logic [2:0]  pst,
    output logic [1:0]  rd_addr,
    output logic [1:0]  rs_addr,
    output logic [1:0]  rt_addr,
    output logic [7:0]  imm,
    output logic        wb_strobe,
    output logic        busy,
    output logic [7:0]  instr_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_WRITEBACK = 3'b011,
        ST_DONE      = 3'b100
    } state_t;

    logic [1:0]       sync_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_s;
    logic             press;

    state_t           state_q, state_d;
    logic             latch_en;
    logic             count_en;
    logic             wb_q, wb_d;
    logic             busy_q, busy_d;
    logic [3:0]       op_q;
    logic [1:0]       rd_q, rs_q, rt_q;
    logic [7:0]       imm_q;
    logic [7:0]       count_q;

    assign btn_s = sync_q[1];

    // Debouncer: the accepted level only follows btn_s after it has differed
    // for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (btn_s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = btn_s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Rising edge of the debounced level; releases generate nothing.
    assign press = btn_s & ~db_q & (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        count_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    latch_en = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE:    state_d = ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_DONE;
            ST_DONE: begin
                count_en = 1'b1;
                state_d  = ST_IDLE;
            end
            // Any other encoding recovers to IDLE.
            default:      state_d = ST_IDLE;
        endcase
        // Strobe and busy are registered from the next state so they line up
        // exactly with pst.
        wb_d   = (state_d == ST_WRITEBACK);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            wb_q    <= 1'b0;
            busy_q  <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            count_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_exec};
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            wb_q    <= wb_d;
            busy_q  <= busy_d;
            if (latch_en) begin
                op_q  <= sw_instr[15:12];
                rd_q  <= sw_instr[11:10];
                rs_q  <= sw_instr[9:8];
                rt_q  <= sw_instr[7:6];
                imm_q <= sw_instr[7:0];
            end
            if (count_en) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign Opcode      = op_q;
    assign pst         = state_q;
    assign rd_addr     = rd_q;
    assign rs_addr     = rs_q;
    assign rt_addr     = rt_q;
    assign imm         = imm_q;
    assign wb_strobe   = wb_q;
    assign busy        = busy_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_io_sequencer.sv
module tb_io_sequencer;

    logic        clk;
    logic        rst;
    logic        btn_exec;
    logic [15:0] sw_instr;
    logic [3:0]  Opcode;
    logic [2:0]  pst;
    logic [1:0]  rd_addr, rs_addr, rt_addr;
    logic [7:0]  imm;
    logic        wb_strobe;
    logic        busy;
    logic [7:0]  instr_count;

    io_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_exec   (btn_exec),
        .sw_instr   (sw_instr),
        .Opcode     (Opcode),
        .pst        (pst),
        .rd_addr    (rd_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .imm        (imm),
        .wb_strobe  (wb_strobe),
        .busy       (busy),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [7:0] imm;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic [1:0] rt, input logic [7:0] im);
        exp_t e;
        e.op  = op;
        e.rd  = rd;
        e.rs  = rs;
        e.rt  = rt;
        e.imm = im;
        e.cnt = 8'(pushed);
        pushed++;
        exp_q.push_back(e);
    endtask

    // Press with the given switch word, held for hold cycles, then released
    // long enough for the debounced level to fall again.
    task automatic do_press(input logic [15:0] instr, input int hold);
        @(posedge clk);
        #1;
        sw_instr = instr;
        btn_exec = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        btn_exec = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    // Monitor: checks phase legality and strobes every cycle, compares latched
    // fields against the head of the queue while busy, retires it at DONE.
    logic [2:0] prev_pst = 3'b000;
    logic [7:0] last_cnt = 8'd0;
    always @(negedge clk) begin
        if (rst) begin
            prev_pst = 3'b000;
        end else begin
            logic ok;
            case (prev_pst)
                3'b000:  ok = (pst == 3'b000) || (pst == 3'b001);
                3'b001:  ok = (pst == 3'b010);
                3'b010:  ok = (pst == 3'b011);
                3'b011:  ok = (pst == 3'b100);
                3'b100:  ok = (pst == 3'b000);
                default: ok = 1'b0;
            endcase
            check("phase_step", {29'd0, pst}, ok ? {29'd0, pst} : {29'd0, prev_pst});
            check("busy", {31'd0, busy}, {31'd0, (pst != 3'b000)});
            check("wb_strobe", {31'd0, wb_strobe}, {31'd0, (pst == 3'b011)});
            if (pst != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr", {29'd0, pst}, 32'd0);
                end else begin
                    check("fields", {12'd0, Opcode, rd_addr, rs_addr, rt_addr, imm},
                          {12'd0, exp_q[0].op, exp_q[0].rd, exp_q[0].rs, exp_q[0].rt, exp_q[0].imm});
                    if (pst == 3'b100) begin
                        check("count_at_done", {24'd0, instr_count}, {24'd0, exp_q[0].cnt});
                        $display("[TB] txn op=%h rd=%0d rs=%0d rt=%0d imm=%h count=%0d",
                                 Opcode, rd_addr, rs_addr, rt_addr, imm, instr_count);
                        last_cnt = exp_q[0].cnt;
                        void'(exp_q.pop_front());
                    end
                end
            end else if (prev_pst == 3'b100) begin
                check("count_after_done", {24'd0, instr_count}, {24'd0, last_cnt + 8'd1});
            end
            prev_pst = pst;
        end
    end

    logic [2:0] pst_tbl [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    initial begin
        logic [15:0] w;
        rst      = 1'b1;
        btn_exec = 1'b0;
        sw_instr = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {9'd0, Opcode, pst, rd_addr, rs_addr, rt_addr, imm, wb_strobe, busy},
              32'd0);
        check("reset_count", {24'd0, instr_count}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Bounce shorter than the debounce window is ignored.
        #1;
        for (int i = 0; i < 10; i++) begin
            btn_exec = (i % 2 == 0);
            repeat (2) @(posedge clk);
            #1;
        end
        btn_exec = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bounce_pst", {29'd0, pst}, 32'd0);
        check("bounce_count", {24'd0, instr_count}, 32'd0);

        // Clean press, phase timeline checked edge by edge.
        @(posedge clk);
        #1;
        sw_instr = 16'hC6A5;
        btn_exec = 1'b1;
        push_exp(4'hC, 2'd1, 2'd2, 2'd2, 8'hA5);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("pst_edge%0d", k + 1), {29'd0, pst}, {29'd0, pst_tbl[k]});
            check($sformatf("wb_edge%0d", k + 1), {31'd0, wb_strobe}, {31'd0, (pst_tbl[k] == 3'd3)});
        end
        check("count_first", {24'd0, instr_count}, 32'd1);
        btn_exec = 1'b0;
        repeat (12) @(posedge clk);

        // Held button: exactly one instruction.
        push_exp(4'h2, 2'd2, 2'd3, 2'd0, 8'h3C);
        do_press(16'h2B3C, 50);
        #1;
        check("count_held", {24'd0, instr_count}, 32'd2);

        // Switch change during EXECUTE does not disturb latched fields.
        @(posedge clk);
        #1;
        sw_instr = 16'h1300;
        btn_exec = 1'b1;
        push_exp(4'h1, 2'd0, 2'd3, 2'd0, 8'h00);
        repeat (7) @(posedge clk);
        #1;
        check("in_execute", {29'd0, pst}, 32'd2);
        sw_instr = 16'hF000;
        repeat (3) @(posedge clk);
        #1;
        btn_exec = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("count_third", {24'd0, instr_count}, 32'd3);

        // Asynchronous reset during WRITEBACK.
        @(posedge clk);
        #1;
        sw_instr = 16'h4455;
        btn_exec = 1'b1;
        push_exp(4'h4, 2'd1, 2'd0, 2'd1, 8'h55);
        repeat (8) @(posedge clk);
        #1;
        check("in_writeback", {29'd0, pst}, 32'd3);
        #1;
        rst      = 1'b1;
        btn_exec = 1'b0;
        exp_q.delete();
        pushed = 0;
        #1;
        check("async_rst_outputs", {9'd0, Opcode, pst, rd_addr, rs_addr, rt_addr, imm, wb_strobe, busy},
              32'd0);
        check("async_rst_count", {24'd0, instr_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_pst", {29'd0, pst}, 32'd0);
        check("post_rst_count", {24'd0, instr_count}, 32'd0);

        // 256 presses wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            w = 16'(i * 40503 + 7);
            push_exp(w[15:12], w[11:10], w[9:8], w[7:6], w[7:0]);
            do_press(w, 10);
        end
        #1;
        check("wrap_count", {24'd0, instr_count}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
